// File: rtl/ttt_auto_player_pkg.sv
// Shared definitions for the tic-tac-toe automatic player: cell encoding,
// the winning-line table, the preference order and the controller states.
package ttt_pkg;

  // Cell encoding; 2'b11 is not named and simply counts as occupied.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] HUMAN = 2'b01;
  localparam logic [1:0] OWN   = 2'b10;

  // The eight lines, as 1-based cell numbers, in tie-break order.
  localparam logic [3:0] LINE_TABLE [8][3] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

  // Fallback cell order: centre, corners, then edges.
  localparam logic [3:0] PREF_ORDER [9] = '{
    4'd5, 4'd1, 4'd3, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8
  };

  typedef enum logic [2:0] {
    IDLE,
    SCAN_WIN,
    SCAN_BLOCK,
    SCAN_PREF,
    ISSUE
  } state_t;

  // Extract the 2-bit code of 1-based cell k from an 18-bit board.
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
    return 2'(b >> {k - 4'd1, 1'b0});
  endfunction

  // One-hot button pattern for 1-based cell k (bit k-1).
  function automatic logic [8:0] onehot(input logic [3:0] k);
    return 9'b1 << (k - 4'd1);
  endfunction

endpackage

// File: rtl/ttt_auto_player_if.sv
// Handshake between the game and the automatic player. The game side
// (master) offers a settled board with a start pulse; the player side
// (slave) answers with a button/pc move or a no_move pulse.
interface ttt_auto_player_if;
  logic        start;
  logic [17:0] board;
  logic [8:0]  button;
  logic        pc;
  logic        busy;
  logic        no_move;

  modport master (
    output start, board,
    input  button, pc, busy, no_move
  );

  modport slave (
    input  start, board,
    output button, pc, busy, no_move
  );
endinterface

// File: rtl/ttt_auto_player_line_eval.sv
// Combinational check of one line: reports a hit when two cells carry the
// target mark and the remaining cell is empty, and which position is empty.
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  input  logic [1:0] target,
  output logic       hit,
  output logic [1:0] pos
);

  // Target is never EMPTY, so at most one of these patterns can match.
  always_comb begin
    hit = 1'b0;
    pos = 2'd0;
    if (cell_a == EMPTY && cell_b == target && cell_c == target) begin
      hit = 1'b1;
      pos = 2'd0;
    end else if (cell_a == target && cell_b == EMPTY && cell_c == target) begin
      hit = 1'b1;
      pos = 2'd1;
    end else if (cell_a == target && cell_b == target && cell_c == EMPTY) begin
      hit = 1'b1;
      pos = 2'd2;
    end
  end

endmodule

// File: rtl/ttt_auto_player.sv
// Automatic second player. After a start pulse it snapshots the board,
// then searches one line or cell per cycle: own win, block the human,
// then preference order, and finally drives button/pc like a human would.
module ttt_auto_player
  import ttt_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  ttt_auto_player_if.slave  bus
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

  state_t      state;
  logic        pending;
  logic [17:0] snap;
  logic [3:0]  idx;
  logic [3:0]  hold_cnt;
  logic [8:0]  button_r;
  logic        pc_r;
  logic        busy_r;
  logic        no_move_r;

  logic [3:0]  line_c0, line_c1, line_c2;
  logic [1:0]  target;
  logic        hit;
  logic [1:0]  hit_pos;
  logic [3:0]  hit_cell;
  logic [3:0]  pref_cell;
  logic        pref_empty;

  assign bus.button  = button_r;
  assign bus.pc      = pc_r;
  assign bus.busy    = busy_r;
  assign bus.no_move = no_move_r;

  // Look up the current line / preference slot and resolve the chosen cell.
  always_comb begin
    line_c0  = LINE_TABLE[idx[2:0]][0];
    line_c1  = LINE_TABLE[idx[2:0]][1];
    line_c2  = LINE_TABLE[idx[2:0]][2];
    target   = (state == SCAN_BLOCK) ? HUMAN : OWN;
    case (hit_pos)
      2'd0:    hit_cell = line_c0;
      2'd1:    hit_cell = line_c1;
      default: hit_cell = line_c2;
    endcase
    if (idx <= 4'd8) pref_cell = PREF_ORDER[idx];
    else             pref_cell = 4'd5;
    pref_empty = (cell_of(snap, pref_cell) == EMPTY);
  end

  ttt_line_eval u_line_eval (
    .cell_a (cell_of(snap, line_c0)),
    .cell_b (cell_of(snap, line_c1)),
    .cell_c (cell_of(snap, line_c2)),
    .target (target),
    .hit    (hit),
    .pos    (hit_pos)
  );

  // Main controller: accept, scan, issue; every output is registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      snap      <= '0;
      idx       <= '0;
      hold_cnt  <= '0;
      button_r  <= '0;
      pc_r      <= 1'b0;
      busy_r    <= 1'b0;
      no_move_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          button_r  <= '0;
          pc_r      <= 1'b0;
          no_move_r <= 1'b0;
          if (pending) begin
            pending <= 1'b0;
            busy_r  <= 1'b1;
            state   <= SCAN_WIN;
          end else begin
            busy_r <= 1'b0;
            if (bus.start) begin
              snap    <= bus.board;
              idx     <= '0;
              pending <= 1'b1;
            end
          end
        end

        SCAN_WIN, SCAN_BLOCK: begin
          if (hit) begin
            button_r <= onehot(hit_cell);
            pc_r     <= 1'b1;
            hold_cnt <= HOLD_LOAD;
            state    <= ISSUE;
          end else if (idx == 4'd7) begin
            idx   <= '0;
            state <= (state == SCAN_WIN) ? SCAN_BLOCK : SCAN_PREF;
          end else begin
            idx <= idx + 4'd1;
          end
        end

        SCAN_PREF: begin
          if (no_move_r) begin
            no_move_r <= 1'b0;
            busy_r    <= 1'b0;
            idx       <= '0;
            state     <= IDLE;
          end else if (pref_empty) begin
            button_r <= onehot(pref_cell);
            pc_r     <= 1'b1;
            hold_cnt <= HOLD_LOAD;
            state    <= ISSUE;
          end else if (idx == 4'd8) begin
            no_move_r <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end

        ISSUE: begin
          if (hold_cnt == 4'd0) begin
            button_r <= '0;
            pc_r     <= 1'b0;
            busy_r   <= 1'b0;
            idx      <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_auto_player.sv
// Self-checking bench for ttt_auto_player: a table of boards with
// hand-computed move timing, plus reset / busy-start / board-change sequences.
module tb_ttt_auto_player;
  import ttt_pkg::*;

  localparam logic [1:0] E = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  ttt_auto_player_if bus();

  ttt_auto_player #(.HOLD(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] board;
    int          pc_edge;
    logic [8:0]  button;
    int          pc_len;
    int          busy_fall;
    int          nm_edge;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [17:0] bd(input logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9);
    return {c9, c8, c7, c6, c5, c4, c3, c2, c1};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present a board with a one-cycle start; returns #1 after edge E0.
  task automatic applyStimulus(input logic [17:0] b);
    @(negedge clk);
    bus.board = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Watch ncyc edges after E0; edge numbers are relative to E0.
  task automatic observeMove(input int ncyc, output int pc_rise, output logic [8:0] btn,
                             output int pc_len, output int busy_fall, output int nm_rise,
                             output int nm_len, output int bad_strobe, output logic busy1);
    logic busy_seen;
    pc_rise = 0; btn = '0; pc_len = 0; busy_fall = 0;
    nm_rise = 0; nm_len = 0; bad_strobe = 0; busy1 = 1'b0; busy_seen = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) busy1 = bus.busy;
      if (bus.pc) begin
        if (pc_rise == 0) begin
          pc_rise = n;
          btn = bus.button;
        end
        pc_len++;
      end
      if ((bus.button != 9'd0) != bus.pc) bad_strobe++;
      if (bus.busy) busy_seen = 1'b1;
      else if (busy_seen && busy_fall == 0) busy_fall = n;
      if (bus.no_move) begin
        if (nm_rise == 0) nm_rise = n;
        nm_len++;
      end
    end
  endtask

  initial begin
    int pr, pl, bf, nr, nl, bs;
    logic [8:0] btn;
    logic b1;

    bus.start = 1'b0;
    bus.board = '0;

    vecs[0] = '{bd(E,E,E,E,E,E,E,E,E), 18, 9'h010, 2, 20, 0};
    vecs[1] = '{bd(O,O,E,H,H,E,E,E,E),  2, 9'h004, 2,  4, 0};
    vecs[2] = '{bd(O,E,H,E,H,E,E,E,E), 17, 9'h040, 2, 19, 0};
    vecs[3] = '{bd(O,E,E,E,H,E,E,E,E), 20, 9'h004, 2, 22, 0};
    vecs[4] = '{bd(O,H,O,O,H,H,H,O,O),  0, 9'h000, 0, 27, 26};
    vecs[5] = '{bd(O,E,E,E,O,E,E,E,E),  8, 9'h100, 2, 10, 0};
    vecs[6] = '{bd(O,H,H,H,O,O,O,E,H), 26, 9'h080, 2, 28, 0};
    vecs[7] = '{bd(O,O,X,E,E,E,E,E,E), 18, 9'h010, 2, 20, 0};
    vecs[8] = '{bd(X,X,X,X,X,X,X,X,X),  0, 9'h000, 0, 27, 26};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_button", 32'(bus.button), 32'd0);
    checkOutput("reset_pc", 32'(bus.pc), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_no_move", 32'(bus.no_move), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    // Table-driven moves
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].board);
      observeMove(32, pr, btn, pl, bf, nr, nl, bs, b1);
      checkOutput($sformatf("v%0d_pc_edge", v), 32'(pr), 32'(vecs[v].pc_edge));
      checkOutput($sformatf("v%0d_button", v), 32'(btn), 32'(vecs[v].button));
      checkOutput($sformatf("v%0d_pc_len", v), 32'(pl), 32'(vecs[v].pc_len));
      checkOutput($sformatf("v%0d_busy_fall", v), 32'(bf), 32'(vecs[v].busy_fall));
      checkOutput($sformatf("v%0d_no_move_edge", v), 32'(nr), 32'(vecs[v].nm_edge));
      checkOutput($sformatf("v%0d_no_move_len", v), 32'(nl), (vecs[v].nm_edge != 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("v%0d_strobe_consistency", v), 32'(bs), 32'd0);
      checkOutput($sformatf("v%0d_busy_at_e1", v), 32'(b1), 32'd1);
    end

    // Reset asserted while pc is high
    applyStimulus(bd(E,E,E,E,E,E,E,E,E));
    repeat (18) @(posedge clk);
    #1;
    checkOutput("rst_pc_before", 32'(bus.pc), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_pc_after", 32'(bus.pc), 32'd0);
    checkOutput("rst_button_after", 32'(bus.button), 32'd0);
    checkOutput("rst_busy_after", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    observeMove(10, pr, btn, pl, bf, nr, nl, bs, b1);
    checkOutput("rst_no_tail_pc", 32'(pl), 32'd0);

    // Board change mid-scan, start while busy, start on the last ISSUE edge
    applyStimulus(bd(E,E,E,E,E,E,E,E,E));
    pr = 0; pl = 0; btn = '0; bs = 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (bus.pc) begin
        if (pr == 0) begin
          pr = n;
          btn = bus.button;
        end
        pl++;
      end
      if (bus.no_move) bs++;
      if (n == 3) bus.board = bd(O,O,E,E,E,E,E,E,E);
      if (n == 5) bus.start = 1'b1;
      if (n == 6) bus.start = 1'b0;
      if (n == 19) bus.start = 1'b1;
      if (n == 20) bus.start = 1'b0;
    end
    checkOutput("busy_start_pc_edge", 32'(pr), 32'd18);
    checkOutput("busy_start_button", 32'(btn), 32'h010);
    checkOutput("busy_start_pc_total", 32'(pl), 32'd2);
    checkOutput("busy_start_no_move", 32'(bs), 32'd0);
    checkOutput("busy_start_final_busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
